blocking_dcache: RTL and testbench

BLOCKING_DCACHE -- requirements
Module: blocking_dcache

---
 rtl/blocking_dcache_pkg.sv | 20 ++
 rtl/dcache_line_array.sv | 67 ++++++
 rtl/blocking_dcache.sv | 160 ++++++++++++++++
 tb/tb_blocking_dcache.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/blocking_dcache_pkg.sv
// Shared types and default geometry for the blocking direct-mapped data cache.
// Address layout: [1:0] byte, then word offset, then line index, then tag.
package blocking_dcache_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BYTE_OFF_W = 2;
    localparam int unsigned OFFSET_W   = 2;
    localparam int unsigned INDEX_W    = 4;
    localparam int unsigned TAG_W      = ADDR_W - BYTE_OFF_W - OFFSET_W - INDEX_W;
    localparam int unsigned LINE_W     = (2 ** OFFSET_W) * WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WB_REQ    = 2'd1,
        ST_FILL_REQ  = 2'd2,
        ST_FILL_WAIT = 2'd3
    } dcache_state_e;

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
// One combinational read port plus word-merge store, line fill and dirty-clear writes.
module dcache_line_array
    import blocking_dcache_pkg::*;
#(
    parameter int unsigned NUM_SETS   = 2 ** INDEX_W,
    parameter int unsigned LINE_WORDS = LINE_W / WORD_W,
    localparam int unsigned IDX_BITS  = $clog2(NUM_SETS),
    localparam int unsigned OFF_BITS  = $clog2(LINE_WORDS),
    localparam int unsigned TAG_BITS  = ADDR_W - BYTE_OFF_W - OFF_BITS - IDX_BITS,
    localparam int unsigned LINE_BITS = LINE_WORDS * WORD_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_BITS-1:0]  rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 wr_word_en,
    input  logic [IDX_BITS-1:0]  wr_word_idx,
    input  logic [OFF_BITS-1:0]  wr_word_off,
    input  logic [WORD_W-1:0]    wr_word_data,
    input  logic                 fill_en,
    input  logic [IDX_BITS-1:0]  fill_idx,
    input  logic [TAG_BITS-1:0]  fill_tag,
    input  logic [LINE_BITS-1:0] fill_line,
    input  logic                 clean_en,
    input  logic [IDX_BITS-1:0]  clean_idx
);

    logic [NUM_SETS-1:0]  valid_r;
    logic [NUM_SETS-1:0]  dirty_r;
    logic [TAG_BITS-1:0]  tag_r  [NUM_SETS];
    logic [LINE_BITS-1:0] data_r [NUM_SETS];

    assign rd_valid = valid_r[rd_idx];
    assign rd_dirty = dirty_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_line  = data_r[rd_idx];

    // Line state bits: only these are cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= {NUM_SETS{1'b0}};
            dirty_r <= {NUM_SETS{1'b0}};
        end else if (fill_en) begin
            valid_r[fill_idx] <= 1'b1;
            dirty_r[fill_idx] <= 1'b0;
        end else if (wr_word_en) begin
            dirty_r[wr_word_idx] <= 1'b1;
        end else if (clean_en) begin
            dirty_r[clean_idx] <= 1'b0;
        end
    end

    // Tag and data storage; a store merges one word into the resident line.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_r[fill_idx]  <= fill_tag;
            data_r[fill_idx] <= fill_line;
        end else if (wr_word_en) begin
            data_r[wr_word_idx][wr_word_off*WORD_W +: WORD_W] <= wr_word_data;
        end
    end

endmodule

// File: rtl/blocking_dcache.sv
// Blocking write-back, write-allocate direct-mapped data cache.
// Hits complete combinationally in IDLE; misses stall through write-back and fill.
module blocking_dcache
    import blocking_dcache_pkg::*;
#(
    parameter int unsigned NUM_SETS    = 2 ** INDEX_W,
    parameter int unsigned LINE_WORDS  = LINE_W / WORD_W,
    localparam int unsigned IDX_BITS   = $clog2(NUM_SETS),
    localparam int unsigned OFF_BITS   = $clog2(LINE_WORDS),
    localparam int unsigned LADDR_BITS = ADDR_W - BYTE_OFF_W - OFF_BITS,
    localparam int unsigned TAG_BITS   = LADDR_BITS - IDX_BITS,
    localparam int unsigned LINE_BITS  = LINE_WORDS * WORD_W
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  is_input_valid,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  mem_rw,
    input  logic [WORD_W-1:0]     din,
    output logic                  is_ready,
    output logic                  is_output_valid,
    output logic [WORD_W-1:0]     dout,
    output logic                  is_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [LADDR_BITS-1:0] mem_addr,
    output logic [LINE_BITS-1:0]  mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [LINE_BITS-1:0]  mem_rdata
);

    dcache_state_e state_r, state_nx_s;

    logic [OFF_BITS-1:0]   req_off_s;
    logic [IDX_BITS-1:0]   req_idx_s, rd_idx_s, miss_idx_s;
    logic [TAG_BITS-1:0]   req_tag_s, rd_tag_s, miss_tag_s;
    logic [LINE_BITS-1:0]  rd_line_s;
    logic [WORD_W-1:0]     rd_word_s;
    logic [LADDR_BITS-1:0] miss_laddr_r;
    logic rd_valid_s, rd_dirty_s, is_idle_s, hit_s, miss_s;
    logic wr_word_en_s, fill_en_s, clean_en_s;

    assign req_off_s  = addr[BYTE_OFF_W +: OFF_BITS];
    assign req_idx_s  = addr[BYTE_OFF_W + OFF_BITS +: IDX_BITS];
    assign req_tag_s  = addr[ADDR_W-1 -: TAG_BITS];
    assign miss_idx_s = miss_laddr_r[IDX_BITS-1:0];
    assign miss_tag_s = miss_laddr_r[LADDR_BITS-1 -: TAG_BITS];

    // The miss address is latched so a request dropped mid-miss still completes its fill.
    assign is_idle_s = (state_r == ST_IDLE);
    assign rd_idx_s  = is_idle_s ? req_idx_s : miss_idx_s;
    assign hit_s     = is_input_valid & is_idle_s & rd_valid_s & (rd_tag_s == req_tag_s);
    assign miss_s    = is_input_valid & is_idle_s & ~hit_s;
    assign rd_word_s = rd_line_s[req_off_s*WORD_W +: WORD_W];

    assign is_hit          = hit_s;
    assign is_output_valid = hit_s & ~mem_rw;
    assign dout            = (hit_s & ~mem_rw) ? rd_word_s : {WORD_W{1'b0}};

    assign wr_word_en_s = hit_s & mem_rw;
    assign fill_en_s    = (state_r == ST_FILL_WAIT) & mem_rvalid;
    assign clean_en_s   = (state_r == ST_WB_REQ) & mem_ready;

    dcache_line_array #(
        .NUM_SETS   (NUM_SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_lines (
        .clk          (clk),
        .reset        (reset),
        .rd_idx       (rd_idx_s),
        .rd_valid     (rd_valid_s),
        .rd_dirty     (rd_dirty_s),
        .rd_tag       (rd_tag_s),
        .rd_line      (rd_line_s),
        .wr_word_en   (wr_word_en_s),
        .wr_word_idx  (req_idx_s),
        .wr_word_off  (req_off_s),
        .wr_word_data (din),
        .fill_en      (fill_en_s),
        .fill_idx     (miss_idx_s),
        .fill_tag     (miss_tag_s),
        .fill_line    (mem_rdata),
        .clean_en     (clean_en_s),
        .clean_idx    (miss_idx_s)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Capture the line address of the missing request.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_laddr_r <= {LADDR_BITS{1'b0}};
        end else if (miss_s) begin
            miss_laddr_r <= addr[ADDR_W-1 -: LADDR_BITS];
        end
    end

    // Next-state and memory-side request decode.
    always_comb begin
        state_nx_s = state_r;
        is_ready   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {LADDR_BITS{1'b0}};
        mem_wdata  = {LINE_BITS{1'b0}};
        case (state_r)
            ST_IDLE: begin
                is_ready = 1'b1;
                if (miss_s) begin
                    if (rd_valid_s & rd_dirty_s) begin
                        state_nx_s = ST_WB_REQ;
                    end else begin
                        state_nx_s = ST_FILL_REQ;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WB_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rd_tag_s, miss_idx_s};
                mem_wdata = rd_line_s;
                if (mem_ready) begin
                    state_nx_s = ST_FILL_REQ;
                end else begin
                    state_nx_s = ST_WB_REQ;
                end
            end
            ST_FILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = miss_laddr_r;
                if (mem_ready) begin
                    state_nx_s = ST_FILL_WAIT;
                end else begin
                    state_nx_s = ST_FILL_REQ;
                end
            end
            ST_FILL_WAIT: begin
                if (mem_rvalid) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_FILL_WAIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_blocking_dcache.sv
// Directed self-checking bench for blocking_dcache; the bench plays the backing memory.
module tb_blocking_dcache;

    logic         reset, clk;
    logic         is_input_valid, mem_rw;
    logic [31:0]  addr, din, dout;
    logic         is_ready, is_output_valid, is_hit;
    logic         mem_req, mem_we, mem_ready, mem_rvalid;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [31:0] exp_q[$];

    blocking_dcache dut (
        .reset           (reset),
        .clk             (clk),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_rw          (mem_rw),
        .din             (din),
        .is_ready        (is_ready),
        .is_output_valid (is_output_valid),
        .dout            (dout),
        .is_hit          (is_hit),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a load expected to hit, queue its data, and compare when the output is valid.
    task automatic load_hit(input string tag, input logic [31:0] a, input logic [31:0] e);
        is_input_valid = 1'b1;
        mem_rw         = 1'b0;
        addr           = a;
        exp_q.push_back(e);
        #1;
        check({tag, "_hit"}, is_hit, 1);
        check({tag, "_ov"}, is_output_valid, 1);
        if (is_output_valid === 1'b1 && exp_q.size() > 0) begin
            check({tag, "_dout"}, dout, exp_q.pop_front());
        end
    endtask

    initial begin
        reset = 1'b1; is_input_valid = 1'b0; mem_rw = 1'b0; addr = 32'h0; din = 32'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 128'h0;

        // reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", is_ready, 1);
        check("rst_hit", is_hit, 0);
        check("rst_ov", is_output_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        @(negedge clk); reset = 1'b0;

        // cold load miss and fill
        @(negedge clk); is_input_valid = 1'b1; addr = 32'h100; mem_rw = 1'b0;
        #1; check("cold_hit", is_hit, 0);
        @(negedge clk); #1;
        check("cold_req", mem_req, 1);
        check("cold_we", mem_we, 0);
        check("cold_addr", mem_addr, 28'h0000010);
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0; #1;
        check("wait_req", mem_req, 0);
        check("wait_ready", is_ready, 0);
        mem_rvalid = 1'b1; mem_rdata = {32'h4, 32'h3, 32'h2, 32'h1};
        @(negedge clk); mem_rvalid = 1'b0;
        load_hit("ld100", 32'h100, 32'h1);

        // store hit, then load it back the same cycle it is requested
        @(negedge clk); mem_rw = 1'b1; addr = 32'h104; din = 32'hDEADBEEF; #1;
        check("st_hit", is_hit, 1);
        check("st_ready", is_ready, 1);
        check("st_ov", is_output_valid, 0);
        check("st_dout", dout, 0);
        @(negedge clk); load_hit("ld104", 32'h104, 32'hDEADBEEF);
        @(negedge clk); load_hit("ld108", 32'h108, 32'h3);

        // conflicting load evicts the dirty line
        @(negedge clk); addr = 32'h1100; mem_rw = 1'b0; #1;
        check("conf_hit", is_hit, 0);
        @(negedge clk); #1;
        check("wb_req", mem_req, 1);
        check("wb_we", mem_we, 1);
        check("wb_addr", mem_addr, 28'h0000010);
        check("wb_word1", mem_wdata[63:32], 32'hDEADBEEF);
        check("wb_line", mem_wdata, {32'h4, 32'h3, 32'hDEADBEEF, 32'h1});
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0; #1;
        check("fr_we", mem_we, 0);
        check("fr_addr", mem_addr, 28'h0000110);

        // memory stalls acceptance
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("stall_req", mem_req, 1);
            check("stall_addr", mem_addr, 28'h0000110);
            check("stall_ready", is_ready, 0);
        end

        // rvalid on the accepting edge must not complete the fill
        @(negedge clk); mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = {4{32'hBADBAD00}};
        @(negedge clk); mem_ready = 1'b0; mem_rvalid = 1'b0; #1;
        check("early_rv_ready", is_ready, 0);
        check("early_rv_req", mem_req, 0);
        mem_rvalid = 1'b1; mem_rdata = {32'h8, 32'h7, 32'h6, 32'h5};
        @(negedge clk); mem_rvalid = 1'b0;
        load_hit("ld1100", 32'h1100, 32'h5);
        @(negedge clk); load_hit("ld110c", 32'h110C, 32'h8);

        // clean victim goes straight to fill; reset while waiting abandons it
        @(negedge clk); addr = 32'h100; #1;
        check("cln_hit", is_hit, 0);
        @(negedge clk); #1;
        check("cln_req", mem_req, 1);
        check("cln_we", mem_we, 0);
        check("cln_addr", mem_addr, 28'h0000010);
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0; reset = 1'b1; is_input_valid = 1'b0;
        @(negedge clk); reset = 1'b0; #1;
        check("rstm_req", mem_req, 0);
        check("rstm_ready", is_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = {32'h4, 32'h3, 32'h2, 32'h1};
        @(negedge clk); mem_rvalid = 1'b0; is_input_valid = 1'b1; addr = 32'h100; #1;
        check("rstm_miss", is_hit, 0);
        check("rstm_idle", is_ready, 1);

        // refill, then a spurious rvalid in IDLE must leave the line intact
        @(negedge clk); #1;
        check("refill_addr", mem_addr, 28'h0000010);
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = {32'h4, 32'h3, 32'h2, 32'h1};
        @(negedge clk); mem_rvalid = 1'b0;
        load_hit("refill", 32'h100, 32'h1);
        @(negedge clk); is_input_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = {4{32'hFFFFFFFF}};
        @(negedge clk); mem_rvalid = 1'b0;
        load_hit("spur_10c", 32'h10C, 32'h4);
        @(negedge clk); load_hit("spur_100", 32'h100, 32'h1);

        // request dropped mid-miss: fill still lands at the original address
        @(negedge clk); addr = 32'h204; #1;
        check("drop_hit", is_hit, 0);
        @(negedge clk); is_input_valid = 1'b0; addr = 32'hFFFFFFF0; #1;
        check("drop_req", mem_req, 1);
        check("drop_addr", mem_addr, 28'h0000020);
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
        @(negedge clk); mem_rvalid = 1'b0;
        load_hit("drop_ld", 32'h204, 32'hB);

        @(negedge clk); is_input_valid = 1'b0;
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
